// File: rtl/cellrv32_trng_postproc.sv
// ---------------------------------------------------------------------------
// cellrv32_trng_postproc
// Entropy post-processing between the ring-oscillator source and the TRNG
// pool FIFO: repetition-count health test on every raw bit, optional von
// Neumann de-biasing, and MSB-first byte packing.
//
// Ports
//   clk_i        in   1  clock, rising edge
//   rst_i        in   1  synchronous active-high reset
//   enable_i     in   1  TRNG enable; low acts as a synchronous clear
//   raw_i        in   1  raw entropy bit
//   raw_valid_i  in   1  raw_i is valid this cycle
//   data_o       out  8  assembled random byte (held between strobes)
//   valid_o      out  1  one-cycle strobe for data_o (FIFO we_i)
//   alarm_o      out  1  sticky repetition-count failure flag
// ---------------------------------------------------------------------------
module cellrv32_trng_postproc #(
    parameter bit          POST_PROC_EN = 1'b1,
    parameter int unsigned REP_LIMIT    = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       raw_i,
    input  logic       raw_valid_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       alarm_o
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BIT_W  = 3;

    typedef enum logic {
        PAIR_EMPTY = 1'b0,
        PAIR_HALF  = 1'b1
    } pair_state_e;

    pair_state_e             pair_state_q, pair_state_d;
    logic                    pair_bit_q,   pair_bit_d;
    logic [CNT_W-1:0]        rep_cnt_q,    rep_cnt_d;
    logic                    last_q,       last_d;
    logic [BYTE_W-2:0]       sr_q,         sr_d;
    logic [BIT_W-1:0]        bit_cnt_q,    bit_cnt_d;
    logic [BYTE_W-1:0]       data_q,       data_d;
    logic                    valid_q,      valid_d;
    logic                    alarm_q,      alarm_d;

    logic                    same_c;
    logic [CNT_W:0]          rep_inc_c;
    logic                    trip_c;
    logic                    emit_vld_c;
    logic                    emit_bit_c;

    // Health test, de-bias and packer next-state logic
    always_comb begin
        pair_state_d = pair_state_q;
        pair_bit_d   = pair_bit_q;
        rep_cnt_d    = rep_cnt_q;
        last_d       = last_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        alarm_d      = alarm_q;
        emit_vld_c   = 1'b0;
        emit_bit_c   = 1'b0;

        // rep_cnt of zero means no history since the last clear
        same_c    = (rep_cnt_q != '0) && (raw_i == last_q);
        rep_inc_c = (CNT_W+1)'(rep_cnt_q) + (CNT_W+1)'(1);
        trip_c    = raw_valid_i && same_c && (rep_inc_c == (CNT_W+1)'(REP_LIMIT));

        if (raw_valid_i) begin
            if (same_c) begin
                if (rep_cnt_q != CNT_W'(REP_LIMIT)) begin
                    rep_cnt_d = rep_inc_c[CNT_W-1:0];
                end
            end else begin
                rep_cnt_d = CNT_W'(1);
                last_d    = raw_i;
            end
        end

        if (alarm_q || trip_c) begin
            // Tripping bit and everything after it never reach the packer
            alarm_d      = 1'b1;
            pair_state_d = PAIR_EMPTY;
            bit_cnt_d    = '0;
        end else if (raw_valid_i) begin
            if (POST_PROC_EN) begin
                if (pair_state_q == PAIR_EMPTY) begin
                    pair_state_d = PAIR_HALF;
                    pair_bit_d   = raw_i;
                end else begin
                    pair_state_d = PAIR_EMPTY;
                    emit_vld_c   = (pair_bit_q != raw_i);
                    emit_bit_c   = pair_bit_q;
                end
            end else begin
                emit_vld_c = 1'b1;
                emit_bit_c = raw_i;
            end
        end

        if (emit_vld_c) begin
            sr_d      = {sr_q[BYTE_W-3:0], emit_bit_c};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(7)) begin
                data_d  = {sr_q, emit_bit_c};
                valid_d = 1'b1;
            end
        end
    end

    // State registers; reset and enable-low both zero everything
    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) begin
            pair_state_q <= PAIR_EMPTY;
            pair_bit_q   <= 1'b0;
            rep_cnt_q    <= '0;
            last_q       <= 1'b0;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            pair_state_q <= pair_state_d;
            pair_bit_q   <= pair_bit_d;
            rep_cnt_q    <= rep_cnt_d;
            last_q       <= last_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            alarm_q      <= alarm_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign alarm_o = alarm_q;

endmodule

// File: tb/tb_cellrv32_trng_postproc.sv
// ---------------------------------------------------------------------------
// tb_cellrv32_trng_postproc
// Drives a de-bias instance and a bypass instance from the same raw stream
// and compares both against a behavioural model of the post-processor.
// ---------------------------------------------------------------------------
module tb_cellrv32_trng_postproc;

    localparam int LIMIT = 32;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       enable_i = 1'b0;
    logic       raw_i = 1'b0;
    logic       raw_valid_i = 1'b0;
    logic [7:0] data0, data1;
    logic       valid0, valid1, alarm0, alarm1;

    always #5 clk = ~clk;

    cellrv32_trng_postproc #(.POST_PROC_EN(1'b1), .REP_LIMIT(LIMIT)) u_dbias (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .raw_i(raw_i),
        .raw_valid_i(raw_valid_i), .data_o(data0), .valid_o(valid0), .alarm_o(alarm0)
    );

    cellrv32_trng_postproc #(.POST_PROC_EN(1'b0), .REP_LIMIT(LIMIT)) u_bypass (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .raw_i(raw_i),
        .raw_valid_i(raw_valid_i), .data_o(data1), .valid_o(valid1), .alarm_o(alarm1)
    );

    logic [19:0] obs;
    assign obs = {valid0, data0, alarm0, valid1, data1, alarm1};

    int checks = 0;
    int failures = 0;

    // Behavioural model state, index 0 = de-bias, 1 = bypass
    int m_run[2];
    int m_last[2];
    int m_alarm[2];
    int m_pair_n[2];
    int m_pair_b[2];
    int m_acc[2];
    int m_acc_n[2];
    int m_data[2];
    int m_valid[2];
    logic [19:0] exp_vec;

    int npulse0 = 0, npulse1 = 0;
    logic [7:0] ldata0 = 8'h00, ldata1 = 8'h00;

    function automatic void model_clear(input int p);
        m_run[p] = 0; m_last[p] = 0; m_alarm[p] = 0; m_pair_n[p] = 0;
        m_pair_b[p] = 0; m_acc[p] = 0; m_acc_n[p] = 0; m_data[p] = 0; m_valid[p] = 0;
    endfunction

    function automatic void model_emit(input int p, input int b);
        m_acc[p] = m_acc[p] * 2 + b;
        m_acc_n[p]++;
        if (m_acc_n[p] == 8) begin
            m_data[p] = m_acc[p];
            m_valid[p] = 1;
            m_acc[p] = 0;
            m_acc_n[p] = 0;
        end
    endfunction

    function automatic void model_step(input bit en, input bit rv, input int b, input bit rs);
        for (int p = 0; p < 2; p++) begin
            if (rs || !en) begin
                model_clear(p);
            end else begin
                m_valid[p] = 0;
                if (rv) begin
                    m_run[p] = (m_run[p] > 0 && b == m_last[p]) ? m_run[p] + 1 : 1;
                    m_last[p] = b;
                    if (m_run[p] == LIMIT) m_alarm[p] = 1;
                    if (m_alarm[p] != 0) begin
                        m_pair_n[p] = 0; m_acc[p] = 0; m_acc_n[p] = 0;
                    end else if (p == 1) begin
                        model_emit(p, b);
                    end else if (m_pair_n[p] == 0) begin
                        m_pair_n[p] = 1; m_pair_b[p] = b;
                    end else begin
                        m_pair_n[p] = 0;
                        if (m_pair_b[p] != b) model_emit(p, m_pair_b[p]);
                    end
                end
            end
        end
        exp_vec = {m_valid[0] != 0, 8'(m_data[0]), m_alarm[0] != 0,
                   m_valid[1] != 0, 8'(m_data[1]), m_alarm[1] != 0};
    endfunction

    // One clock: drive inputs, advance the model, record strobes
    task automatic step(input bit en, input bit rv, input bit b, input bit rs);
        rst_i = rs; enable_i = en; raw_valid_i = rv; raw_i = b;
        @(posedge clk);
        #1;
        model_step(en, rv, int'(b), rs);
        if (valid0) begin npulse0++; ldata0 = data0; end
        if (valid1) begin npulse1++; ldata1 = data1; end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs !== 20'h0) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", obs, 20'h0);
        end
    endtask

    task automatic test_debias_55();
        int p0;
        logic [7:0] pat;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        p0 = npulse0;
        pat = 8'h55;
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, 1'b1, pat[i], 1'b0);
            checks++;
            if (obs !== exp_vec) begin failures++; $display("FAIL debias_55_a: got %h expected %h", obs, exp_vec); end
            step(1'b1, 1'b1, ~pat[i], 1'b0);
            checks++;
            if (obs !== exp_vec) begin failures++; $display("FAIL debias_55_b: got %h expected %h", obs, exp_vec); end
        end
        checks++;
        if (valid0 !== 1'b1 || data0 !== 8'h55) begin
            failures++;
            $display("FAIL debias_55_byte: got v=%b d=%h expected v=1 d=55", valid0, data0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (npulse0 - p0 != 1 || valid0 !== 1'b0) begin
            failures++;
            $display("FAIL debias_55_count: got %0d pulses expected 1", npulse0 - p0);
        end
    endtask

    task automatic test_debias_discard();
        int p0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        p0 = npulse0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_vec) begin failures++; $display("FAIL discard_pair: got %h expected %h", obs, exp_vec); end
            step(1'b1, 1'b1, i[0], 1'b0);
            step(1'b1, 1'b1, i[0], 1'b0);
            checks++;
            if (obs !== exp_vec) begin failures++; $display("FAIL discard_same: got %h expected %h", obs, exp_vec); end
        end
        checks++;
        if (npulse0 - p0 != 1 || ldata0 !== 8'hFF) begin
            failures++;
            $display("FAIL discard_byte: got %0d pulses data %h expected 1 pulse data ff", npulse0 - p0, ldata0);
        end
    endtask

    task automatic test_rep_alarm();
        int p0, p1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 31; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (alarm0 !== 1'b0 || alarm1 !== 1'b0 || obs !== exp_vec) begin
            failures++;
            $display("FAIL alarm_31: got %b%b expected 00", alarm0, alarm1);
        end
        for (int i = 0; i < 31; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (alarm0 !== 1'b0 || alarm1 !== 1'b0) begin
            failures++;
            $display("FAIL alarm_early: got %b%b expected 00", alarm0, alarm1);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (alarm0 !== 1'b1 || alarm1 !== 1'b1 || valid1 !== 1'b0) begin
            failures++;
            $display("FAIL alarm_trip: got a=%b%b v1=%b expected a=11 v1=0", alarm0, alarm1, valid1);
        end
        p0 = npulse0; p1 = npulse1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, i[0], 1'b0);
            checks++;
            if (obs !== exp_vec) begin failures++; $display("FAIL alarm_hold: got %h expected %h", obs, exp_vec); end
        end
        checks++;
        if (npulse0 != p0 || npulse1 != p1) begin
            failures++;
            $display("FAIL alarm_gate: got %0d/%0d pulses expected 0/0", npulse0 - p0, npulse1 - p1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (alarm0 !== 1'b0 || alarm1 !== 1'b0) begin
            failures++;
            $display("FAIL alarm_clear: got %b%b expected 00", alarm0, alarm1);
        end
    endtask

    task automatic test_mid_byte_clear();
        int p0;
        logic [7:0] pat;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        // raw_valid alongside enable low must be ignored
        step(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== 20'h0) begin failures++; $display("FAIL midclear_zero: got %h expected 00000", obs); end
        p0 = npulse0;
        pat = 8'hA3;
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, 1'b1, pat[i], 1'b0);
            step(1'b1, 1'b1, ~pat[i], 1'b0);
            checks++;
            if (obs !== exp_vec) begin failures++; $display("FAIL midclear_step: got %h expected %h", obs, exp_vec); end
        end
        checks++;
        if (npulse0 - p0 != 1 || ldata0 !== 8'hA3) begin
            failures++;
            $display("FAIL midclear_byte: got %0d pulses data %h expected 1 pulse data a3", npulse0 - p0, ldata0);
        end
    endtask

    task automatic test_bypass();
        int p1;
        logic [7:0] pat;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        p1 = npulse1;
        pat = 8'hB2;
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, 1'b1, pat[i], 1'b0);
            checks++;
            if (obs !== exp_vec) begin failures++; $display("FAIL bypass_b2_step: got %h expected %h", obs, exp_vec); end
        end
        checks++;
        if (valid1 !== 1'b1 || data1 !== 8'hB2) begin
            failures++;
            $display("FAIL bypass_b2: got v=%b d=%h expected v=1 d=b2", valid1, data1);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (valid1 !== 1'b1 || data1 !== 8'hFF || npulse1 - p1 != 2) begin
            failures++;
            $display("FAIL bypass_ff: got v=%b d=%h n=%0d expected v=1 d=ff n=2", valid1, data1, npulse1 - p1);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (valid1 !== 1'b0 || data1 !== 8'hFF) begin
            failures++;
            $display("FAIL bypass_hold: got v=%b d=%h expected v=0 d=ff", valid1, data1);
        end
    endtask

    task automatic test_reset_collision();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, i[0], 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs !== 20'h0 || exp_vec !== obs) begin
            failures++;
            $display("FAIL reset_collision: got %h expected 00000", obs);
        end
    endtask

    task automatic test_random();
        int bias;
        bit en, rv, b, rs;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: bias = 50;
                    1: bias = 90;
                    default: bias = 100;
                endcase
            end
            rs = ($urandom_range(0, 499) == 0);
            en = ($urandom_range(0, 149) != 0);
            rv = ($urandom_range(0, 3) != 0);
            b  = (int'($urandom_range(0, 99)) < bias);
            step(en, rv, b, rs);
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL random_cycle_%0d: got %h expected %h", i, obs, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_debias_55();
        test_debias_discard();
        test_rep_alarm();
        test_mid_byte_clear();
        test_bypass();
        test_reset_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cellrv32_trng_postproc.md
# cellrv32_trng_postproc

Entropy post-processing stage that sits between the ring-oscillator entropy source and the TRNG random-pool FIFO. It takes a raw single-bit sample stream and runs a repetition-count health test on every raw bit. It applies von Neumann de-biasing and packs the surviving bits into bytes. Each finished byte is presented as an 8-bit word with a one-cycle write strobe, wired directly to the pool FIFO's `wdata_i`/`we_i`.

## Interface
- `POST_PROC_EN`, default 1: 1 = von Neumann de-biasing active; 0 = bypass, so every raw bit goes straight to the byte packer.
- `REP_LIMIT`, default 32: number of consecutive identical raw bits that trips the health alarm. Legal range 2..255.

- `clk_i`  in  1  global clock, rising edge; the block's single clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `enable_i`  in  1  TRNG enable from the control register; low acts as a synchronous clear.
- `raw_i`  in  1  raw entropy bit.
- `raw_valid_i`  in  1  strobe: `raw_i` is valid this cycle; may be high on consecutive cycles.
- `data_o`  out  8  assembled random byte.
- `valid_o`  out  1  one-cycle strobe: `data_o` is valid; drives the FIFO `we_i`.
- `alarm_o`  out  1  sticky health-test failure flag.

## Operation
- **Clear priority**
  - Priority order: `rst_i` > `enable_i`=0 > normal operation.
  - The clear condition is `rst_i`=1 or `enable_i`=0.
  - While the clear condition holds, all internal state is zeroed: pair flag, pair bit, repetition counter and last-bit register, shift register, bit counter, and alarm.
- **Repetition-count test**, evaluated on every sampled raw bit regardless of the alarm:
  - First bit after a clear: `last` <= bit, `rep_cnt` <= 1.
  - Bit equal to `last`: `rep_cnt` <= `rep_cnt`+1, saturating at `REP_LIMIT`.
  - Bit different from `last`: `rep_cnt` <= 1 and `last` <= bit.
  - When the incremented count equals `REP_LIMIT`, `alarm_o` <= 1.
  - `alarm_o` is sticky; only the clear condition resets it.
- **Alarm gating**
  - The raw bit that trips the alarm, and every bit after it, are dropped from the de-bias and pack path.
  - The pair flag and bit counter are cleared in the same cycle, so the partial byte is discarded.
  - No `valid_o` pulses while `alarm_o`=1.
- **De-bias** (`POST_PROC_EN`=1). States are PAIR_EMPTY and PAIR_HALF.
  - PAIR_EMPTY + sampled bit: store the bit, go to PAIR_HALF.
  - PAIR_HALF + sampled bit b: go to PAIR_EMPTY.
    - If stored bit != b, emit the stored bit to the packer.
    - If equal (00 or 11), discard both bits.
- **Bypass** (`POST_PROC_EN`=0): every sampled raw bit is emitted to the packer.
- **Packer**
  - `sr` <= {`sr`[6:0], bit}: shifts left, new bit enters at the LSB, so the first emitted bit ends up as `data_o`[7].
  - A 3-bit counter counts emitted bits.
  - On the 8th emitted bit:
    - `data_o` <= {`sr`[6:0], bit}.
    - `valid_o` <= 1 for one cycle.
    - Counter wraps to 0.
- **Flow control**: the downstream FIFO is in safe mode, so no backpressure is provided. A byte produced while the FIFO is full is lost; this is acceptable.

## Timing
- **Reset values**: `data_o`=0x00, `valid_o`=0, `alarm_o`=0. The same values are forced whenever `enable_i`=0.
- **Latency**: `valid_o` is high in the cycle immediately after the `clk_i` edge that samples the raw bit completing the 8th emitted bit. There is no combinational path from inputs to outputs.
- `data_o` holds its last byte between strobes.
- **Throughput**: one raw bit per cycle.
  - Bypass: at most one byte every 8 cycles.
  - De-bias: at most one byte every 16 cycles.
- **`alarm_o` timing**: asserts in the cycle after the `REP_LIMIT`-th identical bit is sampled.
- **Alarm/byte collision**: if the tripping bit would also have completed a byte, the alarm wins and `valid_o` stays 0.
- **`enable_i` falling edge**: `enable_i` sampled low at an edge clears the block at that edge. A `raw_valid_i` in the same cycle is ignored.
- **`enable_i` rising edge**: the block starts fresh from PAIR_EMPTY, with bit counter 0 and no repetition history.

## Test plan
- **De-bias, 0x55**: `POST_PROC_EN`=1, `REP_LIMIT`=32. Feed raw pairs 01,10,01,10,01,10,01,10 on consecutive cycles. Expect exactly one `valid_o` pulse, `data_o`=0x55, one cycle after the 16th raw bit.
- **De-bias discard**: interleave pairs 00 and 11 between eight 10 pairs. Expect exactly one pulse with `data_o`=0xFF; the 00/11 pairs contribute nothing.
- **Repetition alarm**: `REP_LIMIT`=32.
  - 31 ones then a 0: `alarm_o` stays 0.
  - Then 32 ones: `alarm_o`=1 one cycle after the 32nd, and no `valid_o` afterwards despite further alternating input.
  - Drop `enable_i` for one cycle: `alarm_o`=0.
- **Mid-byte clear**: emit 5 de-biased bits, pulse `enable_i` low for one cycle, then feed the pattern producing 0xA3. Expect a single byte of 0xA3, with no stale bits.
- **Bypass**: `POST_PROC_EN`=0. Raw 1,0,1,1,0,0,1,0 gives `data_o`=0xB2. Then 8 raw ones gives 0xFF, two strobes total.
- **Reset during operation**: assert `rst_i` in the same cycle as a byte-completing `raw_valid_i`. Expect `valid_o`=0, `data_o`=0x00, `alarm_o`=0 the next cycle.
